// File: rtl/xy_vector_scanner.sv
// xy_vector_scanner: writable-vertex XY polyline generator with per-point dwell, frame trigger
// and optional pen-up blanking (enable with macro XY_BLANK_EN).
`default_nettype none

module xy_vector_scanner #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int NVERT     = 4,
    parameter int STEP_LOG2 = 2,
    parameter int HOLD_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [HOLD_W-1:0]        hold,
    input  logic                     vert_we,
    input  logic [$clog2(NVERT)-1:0] vert_addr,
    input  logic [X_W-1:0]           vert_x,
    input  logic [Y_W-1:0]           vert_y,
    input  logic                     vert_pen,
    output logic [X_W-1:0]           x_out,
    output logic [Y_W-1:0]           y_out,
    output logic                     trig,
    output logic                     blank,
    output logic                     frame_done
);

    localparam int AW = $clog2(NVERT);
    localparam int XI = X_W + 1 + STEP_LOG2;
    localparam int YI = Y_W + 1 + STEP_LOG2;
    localparam logic [AW-1:0]        SEG_ONE   = AW'(1);
    localparam logic [AW-1:0]        SEG_LAST  = AW'(NVERT - 1);
    localparam logic [STEP_LOG2-1:0] K_ONE     = STEP_LOG2'(1);
    localparam logic [STEP_LOG2-1:0] K_LAST    = '1;
    localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]    HOLD_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [X_W-1:0]       tab_x [NVERT];
    logic [Y_W-1:0]       tab_y [NVERT];
    logic [AW-1:0]        seg;
    logic [AW-1:0]        seg_nxt;
    logic [STEP_LOG2-1:0] k;
    logic [STEP_LOG2-1:0] k_nxt;
    logic [HOLD_W-1:0]    dwell;
    logic [X_W-1:0]       ax, bx, pt_x;
    logic [Y_W-1:0]       ay, by, pt_y;
    logic signed [XI-1:0] dx;
    logic signed [YI-1:0] dy;
    logic                 expire;
    logic                 seg_pen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NVERT; i++) begin
                tab_x[i] <= '0;
                tab_y[i] <= '0;
            end
        end else if (vert_we) begin
            tab_x[vert_addr] <= vert_x;
            tab_y[vert_addr] <= vert_y;
        end
    end

`ifdef XY_BLANK_EN
    logic [NVERT-1:0] tab_pen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tab_pen <= '1;
        end else if (vert_we) begin
            tab_pen[vert_addr] <= vert_pen;
        end
    end

    assign seg_pen = tab_pen[seg];
`else
    // Without pen storage every segment is drawn, so the blank flop stays at 0.
    logic unused_pen;
    assign unused_pen = vert_pen;
    assign seg_pen    = 1'b1;
`endif

    assign seg_nxt = seg + SEG_ONE;
    assign k_nxt   = k + K_ONE;
    assign expire  = (dwell == HOLD_ZERO);

    // Next point = A + floor((B-A)*k / 2**S); widened so the product and sign never overflow.
    assign dx   = $signed({{(XI-X_W){1'b0}}, bx}) - $signed({{(XI-X_W){1'b0}}, ax});
    assign dy   = $signed({{(YI-Y_W){1'b0}}, by}) - $signed({{(YI-Y_W){1'b0}}, ay});
    assign pt_x = X_W'($signed({1'b0, ax})
                  + ((dx * $signed({{(XI-STEP_LOG2){1'b0}}, k_nxt})) >>> STEP_LOG2));
    assign pt_y = Y_W'($signed({1'b0, ay})
                  + ((dy * $signed({{(YI-STEP_LOG2){1'b0}}, k_nxt})) >>> STEP_LOG2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (en) state_nxt = S_LOAD;
            S_LOAD: state_nxt = en ? S_DRAW : S_IDLE;
            S_DRAW: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (expire && (k == K_LAST)) begin
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= '0;
            k          <= '0;
            dwell      <= '0;
            ax         <= '0;
            ay         <= '0;
            bx         <= '0;
            by         <= '0;
            x_out      <= '0;
            y_out      <= '0;
            trig       <= 1'b0;
            blank      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!en) begin
                // Stopping always rewinds to segment 0; the beam position is left where it was.
                seg  <= '0;
                k    <= '0;
                trig <= 1'b0;
            end else begin
                case (state)
                    S_LOAD: begin
                        ax    <= tab_x[seg];
                        ay    <= tab_y[seg];
                        bx    <= tab_x[seg_nxt];
                        by    <= tab_y[seg_nxt];
                        dwell <= hold;
                        x_out <= tab_x[seg];
                        y_out <= tab_y[seg];
                        blank <= ~seg_pen;
                        trig  <= (seg == '0);
                        k     <= '0;
                    end
                    S_DRAW: begin
                        if (expire) begin
                            if (k != K_LAST) begin
                                k     <= k_nxt;
                                x_out <= pt_x;
                                y_out <= pt_y;
                                dwell <= hold;
                                trig  <= 1'b0;
                            end else begin
                                seg        <= seg_nxt;
                                k          <= '0;
                                frame_done <= (seg == SEG_LAST);
                            end
                        end else begin
                            dwell <= dwell - HOLD_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
